// File: rtl/div_pkg.sv
// ==========================================================================
// div_pkg : shared types and helpers for the seq_restoring_div divider
// Rev 1.0
// ==========================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Bits needed to hold an iteration count of w down to 0.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ==========================================================================
// div_step : one combinational restoring-division iteration
// Rev 1.0
// ==========================================================================
`default_nettype none

module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The running remainder is always below the divisor, so it fits in WIDTH
  // bits; only the shifted value needs the extra bit for the trial subtract.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/seq_restoring_div.sv
// ==========================================================================
// seq_restoring_div : multi-cycle restoring divider, start/busy/done handshake
// Optional macro SIGNED_DIV_EN: two's-complement operands, one extra cycle.
// Rev 1.0
// ==========================================================================
`default_nettype none

module seq_restoring_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  // One spare bit so the signed build can count WIDTH+1 cycles.
  localparam int CW = cnt_width(WIDTH) + 1;

`ifdef SIGNED_DIV_EN
  localparam logic [CW-1:0] C_LOAD = CW'(WIDTH + 1);
`else
  localparam logic [CW-1:0] C_LOAD = CW'(WIDTH);
`endif
  localparam logic [CW-1:0] C_ONE = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef SIGNED_DIV_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  // Most-negative magnitude is representable as an unsigned WIDTH value.
  always_comb begin
    a_mag = A[WIDTH-1] ? (-A) : A;
    b_mag = B[WIDTH-1] ? (-B) : B;
  end
`else
  always_comb begin
    a_mag = A;
    b_mag = B;
  end
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          if (B == '0) begin
            // Zero divisor skips the datapath and reports straight away.
            state_d = FIN;
            q_d     = '1;
            r_d     = A;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = C_LOAD;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            q_d     = '0;
            r_d     = '0;
            dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
            rneg_d  = A[WIDTH-1];
`endif
          end
        end
      end

      RUN: begin
`ifdef SIGNED_DIV_EN
        if (cnt_q == C_ONE) begin
          // Final cycle is the sign fix-up on the finished magnitudes.
          cnt_d   = '0;
          q_d     = qneg_q ? (-quo_q) : quo_q;
          r_d     = rneg_q ? (-rem_q) : rem_q;
          state_d = FIN;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - C_ONE;
        end
`else
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - C_ONE;
        if (cnt_q == C_ONE) begin
          q_d     = step_quo;
          r_d     = step_rem;
          state_d = FIN;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == FIN);
    Q           = q_q;
    R           = r_q;
    div_by_zero = dbz_q;
  end

endmodule

`default_nettype wire

// File: doc/seq_restoring_div.md
Name: seq_restoring_div

Overview:
Multi-cycle restoring divider, the inverse companion of the team's 4-bit ripple-carry add/subtract unit. It produces quotient and remainder one bit per clock, using a trial subtract followed by a restore. Sits beside the adder/subtractor in the arithmetic datapath. A start/busy/done handshake lets the surrounding controller issue one division at a time.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a division; sampled only when busy=0
A  input  WIDTH  dividend, captured on accepted start
B  input  WIDTH  divisor, captured on accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse: Q/R/div_by_zero valid
Q  output  WIDTH  quotient, held until next accepted start
R  output  WIDTH  remainder, held until next accepted start
div_by_zero  output  1  set with done when the captured B==0; held with Q/R

Behaviour:
- Reset (rst=1 at a clk edge):
  - state->IDLE.
  - busy=0, done=0, Q=0, R=0, div_by_zero=0, iteration counter=0.
  - Reset has priority over every other event, including mid-operation; an in-flight division is discarded.
- States: IDLE, RUN, FIN.
- IDLE/FIN with start=1 and B!=0:
  - Capture A, B.
  - Partial remainder (WIDTH+1 bits)=0; quotient shift register=A.
  - counter=WIDTH; state->RUN; busy=1.
  - Q/R/div_by_zero are cleared to 0 on acceptance.
- IDLE/FIN with start=1 and B==0:
  - state->FIN directly; busy stays 0.
  - Next cycle: done=1, div_by_zero=1, Q=all ones, R=A.
- RUN, each edge:
  - Shift {rem,quo} left by 1.
  - trial = rem - {0,B}, evaluated at WIDTH+1 bits.
  - If trial is non-negative (MSB=0): rem=trial, quo LSB=1.
  - Else: keep rem (restore), quo LSB=0.
  - counter decrements by 1.
- RUN, when counter reaches 0 after the step: load Q=quo, R=rem[WIDTH-1:0]; state->FIN; busy=0.
- FIN: done=1 for exactly this one cycle. Without start, the next edge goes to IDLE.
- Latency:
  - Accepted start at edge k -> done high in the cycle following edge k+WIDTH.
  - Divide-by-zero path: done high in the cycle following edge k+1.
- start while busy=1: ignored; no effect on the operation in progress.
- start in the FIN cycle: accepted (back-to-back issue). done still pulses for the finished result.
- A/B changes after acceptance have no effect.
- done is never high while busy=1.

Optional Feature:
SIGNED_DIV_EN
- Defined: A, B are two's complement.
  - Magnitudes are divided unsigned by the same core.
  - Q is negated when sign(A)!=sign(B); R takes the sign of A (truncation toward zero).
  - Sign fix-up adds one cycle: done follows edge k+WIDTH+1.
  - Most-negative / -1: Q wraps to the most-negative value, R=0, no flag.
  - B==0: Q=all ones, R=A, div_by_zero=1.
- Undefined: unsigned only, latency as above, no fix-up cycle.

Decomposition:
- Package div_pkg:
  - state typedef (IDLE, RUN, FIN).
  - DIV_WIDTH_DEFAULT=4.
  - Counter-width function clog2(WIDTH+1).
- Sub-module div_step: combinational single iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Internally a WIDTH+1 subtract plus restore mux.
- The top module owns the FSM, counter, output registers and sign handling.

Test Plan:
- A=13, B=3, start 1 cycle -> busy=1 for 4 cycles; done pulse 5 cycles after start; Q=4, R=1, div_by_zero=0.
- A=7, B=0 -> done next cycle with Q=4'hF, R=7, div_by_zero=1; busy never asserted.
- Boundary cases:
  - A=15, B=1 -> Q=15, R=0.
  - A=3, B=5 -> Q=0, R=3.
  - A=0, B=9 -> Q=0, R=0.
- Handshake:
  - Start 13/3, then pulse start with 9/2 during RUN -> 9/2 ignored; result 4/1.
  - Start 9/2 in the FIN cycle -> accepted; Q=4, R=1 after the next latency.
- Reset mid-RUN after 2 steps -> next cycle all outputs 0, IDLE; a fresh 10/3 afterwards -> Q=3, R=1.
- SIGNED_DIV_EN:
  - A=4'b1001 (-7), B=2 -> Q=4'b1101 (-3), R=4'b1111 (-1), done 6 cycles after start.
  - A=-8, B=-1 -> Q=4'b1000, R=0.
